// File: rtl/div_restoring_pkg.sv
// Shared widths and handshake state encoding for the shift-add multiplier / restoring divider pair.
package div_restoring_pkg;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ITER  = 3'd3,
    ST_END   = 3'd4
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: 17-bit trial subtract of the divisor from {rem, msb}.
module div_restoring_step
  import div_restoring_pkg::*;
(
  input  logic [OP_W:0]   t,
  input  logic [OP_W-1:0] dsr,
  output logic [OP_W-1:0] rem_next,
  output logic            qbit
);

  logic [OP_W:0] diff;

  // rem < dsr on entry, so the difference always fits OP_W bits when it is taken
  always_comb begin
    diff     = t - {1'b0, dsr};
    qbit     = (t >= {1'b0, dsr});
    rem_next = qbit ? diff[OP_W-1:0] : t[OP_W-1:0];
  end

endmodule

// File: rtl/div_restoring.sv
// Sequential 32/16 restoring divider with init/done handshake; one quotient bit per clock.
module div_restoring
  import div_restoring_pkg::*;
#(
  parameter int unsigned DONE_HOLD = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2*OP_W-1:0] op_A,
  input  logic [OP_W-1:0]   op_B,
  output logic [OP_W-1:0]   quotient,
  output logic [OP_W-1:0]   remainder,
  output logic              overflow,
  output logic              done
);

  state_t            state;
  logic [OP_W-1:0]   rem;
  logic [OP_W-1:0]   dvd;
  logic [OP_W-1:0]   dsr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  count;
  logic [OP_W:0]     step_t;
  logic [OP_W-1:0]   step_rem;
  logic              step_q;

  assign step_t = {rem, dvd[OP_W-1]};

  div_restoring_step u_step (
    .t        (step_t),
    .dsr      (dsr),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      bit_cnt   <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          count <= '0;
          if (init) state <= ST_LOAD;
        end
        ST_LOAD: begin
          rem       <= op_A[2*OP_W-1:OP_W];
          dvd       <= op_A[OP_W-1:0];
          dsr       <= op_B;
          overflow  <= 1'b0;
          quotient  <= '0;
          remainder <= '0;
          state     <= ST_CHECK;
        end
        // Upper half >= divisor means the quotient cannot fit OP_W bits
        ST_CHECK: begin
          if ((dsr == '0) || (rem >= dsr)) begin
            overflow  <= 1'b1;
            quotient  <= '1;
            remainder <= rem;
            state     <= ST_END;
          end else begin
            bit_cnt <= '0;
            state   <= ST_ITER;
          end
        end
        ST_ITER: begin
          rem     <= step_rem;
          dvd     <= {dvd[OP_W-2:0], step_q};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(OP_W - 1)) begin
            quotient  <= {dvd[OP_W-2:0], step_q};
            remainder <= step_rem;
            state     <= ST_END;
          end
        end
        ST_END: begin
          done  <= 1'b1;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(DONE_HOLD - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
